// File: rtl/cnt_down_timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//   BCD_W / BCD_MAX : digit width and largest legal digit value
//   state_t         : timer FSM encoding (IDLE / RUN / DONE)
//   bcd_clamp()     : saturates an illegal nibble (A-F) to 9
package cnt_down_timer_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/cnt_down_timer_if.sv
// Control/status bundle of the countdown timer.
//   ld, din, en           : load strobe, BCD load value, count tick (master -> slave)
//   q, busy, done, tc     : count, run/done status, terminal-count pulse (slave -> master)
interface cnt_down_timer_if #(parameter int DIGITS = 2);

  logic                  ld;
  logic [4*DIGITS-1:0]   din;
  logic                  en;
  logic [4*DIGITS-1:0]   q;
  logic                  busy;
  logic                  done;
  logic                  tc;

  modport master (output ld, din, en, input  q, busy, done, tc);
  modport slave  (input  ld, din, en, output q, busy, done, tc);

endinterface

// File: rtl/cnt_down_digit.sv
// One BCD digit of the down-counter chain.
//   ck, res : clock, synchronous active-low reset
//   ld, d   : load strobe and (already clamped) load digit
//   bi      : borrow in, the digit steps down when high
//   q       : registered digit value
//   bo      : borrow out to the next digit (combinational)
module cnt_down_digit
  import cnt_down_timer_pkg::*;
(
  input  logic             ck,
  input  logic             res,
  input  logic             ld,
  input  logic [BCD_W-1:0] d,
  input  logic             bi,
  output logic [BCD_W-1:0] q,
  output logic             bo
);

  always_ff @(posedge ck) begin
    if (!res)    q <= '0;
    else if (ld) q <= d;
    else if (bi) q <= (q == '0) ? BCD_MAX : q - 1'b1;
  end

  // borrow ripples only through digits sitting at zero
  assign bo = bi & (q == '0);

endmodule

// File: rtl/cnt_down_timer.sv
// Cascadable BCD countdown timer.
//   ck, res : clock, synchronous active-low reset
//   bus     : ld/din/en in; q/busy/done/tc out (see cnt_down_timer_if)
// Load clamps each digit to 9; a non-zero load enters RUN, a zero load goes
// straight to DONE. In RUN each en cycle decrements by one; reaching zero
// enters DONE with a single-cycle tc pulse.
module cnt_down_timer
  import cnt_down_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                ck,
  input  logic                res,
  cnt_down_timer_if.slave     bus
);

  localparam int W = BCD_W * DIGITS;

  state_t                          state, state_nxt;
  logic                            tc_q, tc_nxt;
  logic [DIGITS-1:0][BCD_W-1:0]    din_c;
  logic [DIGITS-1:0][BCD_W-1:0]    qd;
  logic [DIGITS:0]                 bc;
  logic                            ld_zero;
  logic                            q_one;
  logic                            unused_bo;

  // chain head: only RUN counts; DONE/IDLE ignore en so DONE never wraps to 9s
  assign bc[0] = bus.en & (state == ST_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign din_c[gi] = bcd_clamp(bus.din[gi*BCD_W +: BCD_W]);
      cnt_down_digit u_dig (
        .ck (ck),
        .res(res),
        .ld (bus.ld),
        .d  (din_c[gi]),
        .bi (bc[gi]),
        .q  (qd[gi]),
        .bo (bc[gi+1])
      );
    end
  endgenerate

  // borrow out of the top digit would mean underflow, which RUN never reaches
  assign unused_bo = bc[DIGITS];

  assign ld_zero = (din_c == '0);
  assign q_one   = (qd == W'(1));

  always_comb begin
    state_nxt = state;
    tc_nxt    = 1'b0;
    if (bus.ld) begin
      state_nxt = ld_zero ? ST_DONE : ST_RUN;
    end else if (state == ST_RUN && bus.en && q_one) begin
      state_nxt = ST_DONE;
      tc_nxt    = 1'b1;
    end
  end

  always_ff @(posedge ck) begin
    if (!res) begin
      state <= ST_IDLE;
      tc_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      tc_q  <= tc_nxt;
    end
  end

  assign bus.q    = qd;
  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);
  assign bus.tc   = tc_q;

endmodule
